qr_text_buf: RTL

//   Output stage after the QR codeword decoder. Captures the decoded byte stream
//   (one byte per cycle, no backpressure) into a FIFO and serves it to the host

---
 rtl/qr_pkg.sv | 20 ++
 rtl/qr_sync_fifo.sv | 60 ++++++
 rtl/qr_text_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/qr_pkg.sv
// Shared types and constants for the QR text output buffer.
package qr_pkg;

  localparam int QR_DW        = 8;
  localparam int QR_MAX_BYTES = 26;
  localparam int QR_LEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Message length counter saturates instead of wrapping.
  function automatic logic [QR_LEN_W-1:0] sat_inc(input logic [QR_LEN_W-1:0] v);
    return (v == {QR_LEN_W{1'b1}}) ? v : v + QR_LEN_W'(1);
  endfunction

endpackage

// File: rtl/qr_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module qr_sync_fifo #(
  parameter  int DEPTH = 32,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [CW-1:0] count_o,
  output logic          accepted_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_pop     = pop_i & ~empty;
  assign do_push    = push_i & (~full | do_pop);
  assign accepted_o = do_push;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // NOTE: storage has no reset; stale entries are unreachable because the
  // pointers and count are reset, and it keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qr_text_buf.sv
// Buffers the decoded QR byte stream and serves it to the host, holding back
// the newest byte until end-of-message is known so it can be tagged as last.
module qr_text_buf
  import qr_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = QR_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  input  logic                in_finish,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                overflow,
  output logic [QR_LEN_W-1:0] msg_len,
  output logic                msg_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e                state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic [QR_LEN_W-1:0]   len_q, len_d;
  logic [CW-1:0]         count;
  logic [DW-1:0]         head;
  logic                  push_req, pop, accepted;

  assign push_req = in_valid & ((state_q == IDLE) | (state_q == RECV));
  assign pop      = out_valid & out_ready;

  qr_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_req),
    .wdata_i    (in_data),
    .pop_i      (pop),
    .rdata_o    (head),
    .count_o    (count),
    .accepted_o (accepted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      len_q      <= len_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid)       state_d = in_finish ? FLUSH : RECV;
        else if (in_finish) state_d = DONE;
      end
      RECV:  if (in_finish) state_d = FLUSH;
      FLUSH: if ((count == CW'(1)) && out_ready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Length and overflow bookkeeping; a new message resets both on its first byte.
  always_comb begin
    len_d      = len_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          len_d      = QR_LEN_W'(1);
          overflow_d = 1'b0;
        end else if (in_finish) begin
          len_d = '0;
        end
      end
      RECV: begin
        if (in_valid) begin
          if (accepted) len_d      = sat_inc(len_q);
          else          overflow_d = 1'b1;
        end
      end
      default: if (in_valid) overflow_d = 1'b1;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    unique case (state_q)
      RECV:    out_valid = (count >= CW'(2));
      FLUSH:   out_valid = (count != '0);
      default: out_valid = 1'b0;
    endcase
    out_last = (state_q == FLUSH) && (count == CW'(1));
    busy     = (state_q != IDLE);
    msg_done = (state_q == DONE);
    out_data = out_valid ? head : '0;
  end

  assign overflow = overflow_q;
  assign msg_len  = len_q;

endmodule
